// File: rtl/prio_enc_pkg.sv
// Shared definitions for the prio_enc_rr block.
//   prio_mode_e : selects fixed-priority or round-robin arbitration.
//   idx_w(n)    : width of an index into n request lines, at least 1 bit.
//   DEFAULT_*   : parameter defaults used by the top level.
package prio_enc_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } prio_mode_e;

    localparam int DEFAULT_N     = 8;
    localparam int DEFAULT_RR_EN = 1;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_enc_fixed.sv
// Combinational highest-set-bit encoder.
//   req   : N request lines, bit N-1 has the highest priority
//   idx   : index of the highest set bit (0 when none is set)
//   found : at least one request bit is set
module prio_enc_fixed
    import prio_enc_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered N-input priority encoder with fixed or round-robin arbitration
// and valid/ready handshakes on both sides.
//   clk, rst             : clock, synchronous active-high reset
//   number, en, mode     : request vector, enable, arbitration mode
//   in_valid / in_ready  : input handshake (in_ready combinational from out_ready)
//   Y, grant, none       : winning index, one-hot winner, no-winner flag
//   out_valid / out_ready: output handshake
module prio_enc_rr
    import prio_enc_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    parameter  int RR_EN = DEFAULT_RR_EN,
    localparam int W     = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] number,
    input  logic         en,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] Y,
    output logic [N-1:0] grant,
    output logic         none,
    output logic         out_valid,
    input  logic         out_ready
);

    // One extra bit so that sums of two indices never overflow before the
    // explicit mod-N correction.
    localparam logic [W:0]   N_EXT    = (W + 1)'(N);
    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    logic [W-1:0] ptr_reg;
    logic [W-1:0] y_reg;
    logic [N-1:0] grant_reg;
    logic         none_reg;
    logic         out_valid_reg;

    prio_mode_e   mode_e;
    logic         use_rr;
    logic         accept;
    logic [N-1:0] rot_req;
    logic [N-1:0] enc_req;
    logic [W-1:0] enc_idx;
    logic         enc_found;
    logic [W:0]   rr_sum;
    logic [W-1:0] rr_win;
    logic [W-1:0] win_idx;
    logic         hit;
    logic [W-1:0] res_y;
    logic [N-1:0] res_grant;
    logic         res_none;
    logic [W-1:0] ptr_next;

    assign mode_e = prio_mode_e'(mode);
    assign use_rr = (RR_EN != 0) && (mode_e == MODE_RR);

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // Rotate the requests so that requester ptr sits at the MSB:
    // rot_req[j] = number[(ptr + j + 1) mod N]. The highest rotated bit is then
    // the first requester found walking down from ptr with wraparound.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [W:0]   src_sum;
        logic [W-1:0] src_idx;
        assign src_sum     = {1'b0, ptr_reg} + (W + 1)'(gi + 1);
        assign src_idx     = (src_sum >= N_EXT) ? W'(src_sum - N_EXT) : src_sum[W-1:0];
        assign rot_req[gi] = number[src_idx];
    end

    assign enc_req = use_rr ? rot_req : number;

    prio_enc_fixed #(
        .N (N),
        .W (W)
    ) u_enc (
        .req   (enc_req),
        .idx   (enc_idx),
        .found (enc_found)
    );

    // Undo the rotation: winner = (ptr + j + 1) mod N.
    assign rr_sum  = {1'b0, ptr_reg} + {1'b0, enc_idx} + (W + 1)'(1);
    assign rr_win  = (rr_sum >= N_EXT) ? W'(rr_sum - N_EXT) : rr_sum[W-1:0];
    assign win_idx = use_rr ? rr_win : enc_idx;

    assign hit      = en && enc_found;
    assign res_y    = hit ? win_idx : '0;
    assign res_none = !hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign res_grant[gi] = hit && (win_idx == W'(gi));
    end

    // The winner becomes lowest priority on the next round-robin decision.
    assign ptr_next = (win_idx == '0) ? LAST_IDX : win_idx - W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            grant_reg     <= '0;
            none_reg      <= 1'b1;
            ptr_reg       <= LAST_IDX;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                y_reg         <= res_y;
                grant_reg     <= res_grant;
                none_reg      <= res_none;
                if (use_rr && hit) begin
                    ptr_reg <= ptr_next;
                end
            end else if (out_ready) begin
                // Result consumed with nothing new: data outputs keep their values.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign Y         = y_reg;
    assign grant     = grant_reg;
    assign none      = none_reg;
    assign out_valid = out_valid_reg;

endmodule
